alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised multi-cycle successor of the single-cycle RV32I R-type ALU. It executes the ten base R-type operations in one registered cycle. It adds iterative multiply (low/high-unsigned) and divide/remainder (signed/unsigned) that take XLEN cycles. Operands enter and results leave over valid/ready handshakes, so the execute stage can stall on either side.

## Interface
- XLEN, 32: operand/result width; power of two, ≥ 8.
- SHW, $clog2(XLEN): shift-amount width (derived; not overridable).

- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_valid  in  1  operand request valid.
- o_ready  out  1  block can accept a request.
- i_a, i_b  in  XLEN  operands (rs1, rs2).
- i_op  in  4  operation code, see Operation.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_res  out  XLEN  result.
- o_busy  out  1  iterative op in progress.

## Operation
- Opcodes:
  - 0 add, 1 sub.
  - 2 sll, 6 srl, 7 sra: shift by i_b[SHW-1:0].
  - 3 slt (signed), 4 sltu: result zero-extended 0/1.
  - 5 xor, 8 or, 9 and.
  - 10 mul: low XLEN bits of the product.
  - 11 mulhu: high XLEN bits of the unsigned 2·XLEN product.
  - 12 div, 13 divu, 14 rem, 15 remu.
- Request accepted on a cycle where i_valid && o_ready. Operands and op are latched; inputs are ignored afterwards.
- FSM states IDLE, BUSY, DONE:
  - IDLE: o_ready=1. On accept of op 0–9, compute, register into o_res, go to DONE. On accept of op 10–15, go to BUSY, unless a div/rem special case applies; then load the result directly and go to DONE.
  - BUSY: o_ready=0, o_busy=1. One iteration per cycle; a counter counts XLEN iterations, then the result is registered and the state goes to DONE.
  - DONE: o_valid=1, o_ready=0. If i_ready, go to IDLE; otherwise hold o_res stable.
- Multiply: unsigned shift-add over XLEN iterations, with a 2·XLEN accumulator.
- Divide: restoring, one quotient bit per iteration, on magnitudes. Signed ops negate the operands first, then fix signs:
  - quotient is negative iff the operand signs differ;
  - remainder takes the dividend's sign.
- Special cases, RISC-V semantics, resolved at accept (latency 1):
  - divisor 0: div/divu → all ones; rem/remu → i_a.
  - signed overflow (i_a = −2^(XLEN−1), i_b = −1): div → i_a; rem → 0.
- All arithmetic is modulo 2^XLEN. No exceptions or flags.

## Timing
- Reset (i_rst_n=0 at an edge): state IDLE, o_valid=0, o_busy=0, o_res=0, counter=0.
- o_ready is forced 0 while i_rst_n is low, and is 1 from the first cycle after release.
- Reset mid-BUSY or mid-DONE aborts the operation; the pending result is discarded.
- Accept at edge T:
  - ops 0–9 and div special cases: o_valid=1 from cycle T+1.
  - ops 10–15 otherwise: o_busy=1 in cycles T+1 … T+XLEN; o_valid=1 from T+XLEN+1.
- Result handshake completes at the edge where o_valid && i_ready. o_valid drops and o_ready rises the next cycle, so back-to-back single-cycle ops issue every 2 cycles.
- o_valid, once asserted, stays high with o_res unchanged until taken.
- o_ready is combinational from state only; it has no combinational path from i_valid or i_ready.

## Test plan
- Reset, then single-cycle ops back-to-back with i_ready=1:
  - add 0x7FFFFFFF+1 → 0x80000000;
  - sub 0−1 → 0xFFFFFFFF;
  - sra 0x80000000 by i_b=0x21 → 0xC0000000 (only i_b[4:0]=1 used);
  - slt −1<0 → 1; sltu 0xFFFFFFFF<0 → 0.
  - Each result is valid one cycle after accept.
- Multiply 0xFFFFFFFF × 0xFFFFFFFF:
  - mul → 0x00000001; mulhu → 0xFFFFFFFE.
  - o_busy high for exactly 32 cycles; o_valid at T+33; o_ready low throughout.
- Divide:
  - div −7/2 → 0xFFFFFFFD; rem −7/2 → 0xFFFFFFFF;
  - divu 100/7 → 14; remu 100/7 → 2.
- Special cases, each valid at T+1 with o_busy never set:
  - div 5/0 → 0xFFFFFFFF; rem 5/0 → 5;
  - div 0x80000000/−1 → 0x80000000; rem 0x80000000/−1 → 0.
- Backpressure: hold i_ready=0 for 5 cycles after o_valid. o_res stays stable, o_ready stays 0, and a new i_valid is not accepted. Raise i_ready; accept is possible on the following cycle.
- Reset asserted mid-divide (iteration 10):
  - next cycle: o_busy=0, o_valid=0, o_res=0;
  - a new add 2+3 after release → 5 at T+1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: RV32I R-type ALU with single-cycle base ops plus iterative
// multiply (mul/mulhu) and restoring divide (div/divu/rem/remu).
// Operands come in and results go out over valid/ready handshakes.
module alu_seq #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [3:0]      i_op,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_res,
  output logic            o_busy
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {st_idle, st_busy, st_done} state_t;

  state_t              state, state_nxt;
  logic [2*XLEN-1:0]   acc;      // mul: {hi, multiplier}; div: {rem, dividend/quotient}
  logic [XLEN-1:0]     opb;      // multiplicand or divisor magnitude
  logic [3:0]          op_r;
  logic                neg_q, neg_r;
  logic [SHW-1:0]      cnt;

  logic                accept, is_iter, is_div, is_rem, is_sdiv;
  logic                b_zero, ovf, special, last;
  logic [XLEN-1:0]     special_res, alu_res, a_mag, b_mag, fin_res;
  logic [XLEN:0]       msum, dtrial;
  logic [2*XLEN-1:0]   mul_nxt, div_nxt, acc_nxt;
  logic [XLEN-1:0]     q_nxt, r_nxt;

  assign accept  = i_valid && o_ready;
  assign is_iter = (i_op >= 4'd10);
  assign is_div  = (i_op >= 4'd12);
  assign is_rem  = i_op[1];                       // 14/15 vs 12/13
  assign is_sdiv = (i_op == 4'd12) || (i_op == 4'd14);
  assign b_zero  = (i_b == '0);
  assign ovf     = is_sdiv && (i_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_b == '1);
  assign special = is_div && (b_zero || ovf);
  assign special_res = b_zero ? (is_rem ? i_a : '1) : (is_rem ? '0 : i_a);

  // Signed divide works on magnitudes; the most negative value maps onto itself,
  // which as an unsigned magnitude is exactly right.
  assign a_mag = (is_sdiv && i_a[XLEN-1]) ? -i_a : i_a;
  assign b_mag = (is_sdiv && i_b[XLEN-1]) ? -i_b : i_b;

  // One shift-add multiply step: add multiplicand into the high half, shift right.
  assign msum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_nxt = {msum, acc[XLEN-1:1]};

  // One restoring divide step: shift in next dividend bit, subtract if it fits.
  assign dtrial  = acc[2*XLEN-1:XLEN-1] - {1'b0, opb};
  assign div_nxt = dtrial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                : {dtrial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  assign acc_nxt = (op_r[3:2] == 2'b11) ? div_nxt : mul_nxt;
  assign q_nxt   = acc_nxt[XLEN-1:0];
  assign r_nxt   = acc_nxt[2*XLEN-1:XLEN];
  assign last    = (cnt == SHW'(XLEN-1));

  // Final result selection from the value the last iteration produces.
  always_comb begin
    fin_res = '0;
    case (op_r)
      4'd10:        fin_res = q_nxt;
      4'd11:        fin_res = r_nxt;
      4'd12, 4'd13: fin_res = neg_q ? -q_nxt : q_nxt;
      4'd14, 4'd15: fin_res = neg_r ? -r_nxt : r_nxt;
      default:      fin_res = '0;
    endcase
  end

  // Single-cycle base operations.
  always_comb begin
    alu_res = '0;
    case (i_op)
      4'd0:    alu_res = i_a + i_b;
      4'd1:    alu_res = i_a - i_b;
      4'd2:    alu_res = i_a << i_b[SHW-1:0];
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      4'd4:    alu_res = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      4'd5:    alu_res = i_a ^ i_b;
      4'd6:    alu_res = i_a >> i_b[SHW-1:0];
      4'd7:    alu_res = $unsigned($signed(i_a) >>> i_b[SHW-1:0]);
      4'd8:    alu_res = i_a | i_b;
      4'd9:    alu_res = i_a & i_b;
      default: alu_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= st_idle;
    else          state <= state_nxt;
  end

  // Next-state and handshake outputs; o_ready depends on state and reset only.
  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_busy    = 1'b0;
    case (state)
      st_idle: begin
        o_ready = i_rst_n;
        if (accept) state_nxt = (is_iter && !special) ? st_busy : st_done;
      end
      st_busy: begin
        o_busy = 1'b1;
        if (last) state_nxt = st_done;
      end
      st_done: begin
        o_valid = 1'b1;
        if (i_ready) state_nxt = st_idle;
      end
      default: state_nxt = st_idle;
    endcase
  end

  // Datapath: latch operands at accept, iterate while busy, hold result in done.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      acc   <= '0;
      opb   <= '0;
      op_r  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt   <= '0;
      o_res <= '0;
    end else begin
      case (state)
        st_idle: begin
          if (accept) begin
            op_r <= i_op;
            cnt  <= '0;
            if (is_iter && !special) begin
              acc   <= {{XLEN{1'b0}}, is_div ? a_mag : i_a};
              opb   <= is_div ? b_mag : i_b;
              neg_q <= is_sdiv && (i_a[XLEN-1] ^ i_b[XLEN-1]);
              neg_r <= is_sdiv && i_a[XLEN-1];
            end else begin
              o_res <= is_iter ? special_res : alu_res;
            end
          end
        end
        st_busy: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (last) o_res <= fin_res;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a
// behavioural model built from plain 64-bit arithmetic.
module tb_alu_seq;
  localparam int XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic            i_ready = 1'b1;
  logic [XLEN-1:0] i_a = '0, i_b = '0;
  logic [3:0]      i_op = '0;
  logic            o_ready, o_valid, o_busy;
  logic [XLEN-1:0] o_res;

  int errs = 0;
  int checks = 0;

  alu_seq #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_op(i_op), .o_valid(o_valid), .i_ready(i_ready),
    .o_res(o_res), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb;
    logic [4:0]  sh;
    logic [31:0] r;
    p  = {32'b0, a} * {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    r  = '0;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a << sh;
      4'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  r = (a < b) ? 32'd1 : 32'd0;
      4'd5:  r = a ^ b;
      4'd6:  r = a >> sh;
      4'd7:  r = $unsigned($signed(a) >>> sh);
      4'd8:  r = a | b;
      4'd9:  r = a & b;
      4'd10: r = p[31:0];
      4'd11: r = p[63:32];
      4'd12: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      4'd13: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: r = (b == 0) ? a : 32'(sa % sb);
      4'd15: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bit sgn;
    sgn = (op == 4'd12) || (op == 4'd14);
    if (op < 4'd10) return 1;
    if (op >= 4'd12 && (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return XLEN + 1;
  endfunction

  // Issue one request with i_ready=1 and check result, latency, busy span.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat, busyc, el;
    bit rdy_low;
    el = exp_lat(op, a, b);
    @(negedge i_clk);
    chk({tag, "/ready"}, o_ready, 1);
    i_valid = 1'b1; i_op = op; i_a = a; i_b = b; i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_op = 4'($urandom);
    lat = 1; busyc = 0; rdy_low = 1'b1;
    while (!o_valid && lat < 100) begin
      if (o_busy) busyc++;
      if (o_ready) rdy_low = 1'b0;
      @(negedge i_clk);
      lat++;
    end
    chk({tag, "/lat"}, lat, el);
    chk({tag, "/busycyc"}, busyc, el - 1);
    chk({tag, "/res"}, o_res, model(op, a, b));
    chk({tag, "/busy@valid"}, o_busy, 0);
    if (el > 1) chk({tag, "/readylow"}, rdy_low, 1);
    @(negedge i_clk);
    chk({tag, "/validdrop"}, o_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held, ea, eb;
    logic [3:0]  rop;

    // Reset state
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst/ready", o_ready, 0);
    chk("rst/valid", o_valid, 0);
    chk("rst/busy", o_busy, 0);
    chk("rst/res", o_res, 0);
    i_rst_n = 1'b1;

    // Single-cycle ops
    do_op(4'd0, 32'h7FFF_FFFF, 32'h1, "add");
    do_op(4'd1, 32'h0, 32'h1, "sub");
    do_op(4'd7, 32'h8000_0000, 32'h21, "sra");
    do_op(4'd3, 32'hFFFF_FFFF, 32'h0, "slt");
    do_op(4'd4, 32'hFFFF_FFFF, 32'h0, "sltu");
    do_op(4'd2, 32'h0000_0003, 32'h1F, "sll");
    do_op(4'd6, 32'h8000_0000, 32'h04, "srl");
    do_op(4'd5, 32'hF0F0_1234, 32'h0FF0_FFFF, "xor");
    do_op(4'd8, 32'hF000_0001, 32'h0000_0F00, "or");
    do_op(4'd9, 32'hF0F0_FFFF, 32'h3C3C_0F0F, "and");

    // Multiply
    do_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul");
    do_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");

    // Divide
    do_op(4'd12, 32'hFFFF_FFF9, 32'd2, "div");
    do_op(4'd14, 32'hFFFF_FFF9, 32'd2, "rem");
    do_op(4'd13, 32'd100, 32'd7, "divu");
    do_op(4'd15, 32'd100, 32'd7, "remu");

    // Special cases
    do_op(4'd12, 32'd5, 32'd0, "div0");
    do_op(4'd14, 32'd5, 32'd0, "rem0");
    do_op(4'd13, 32'd5, 32'd0, "divu0");
    do_op(4'd15, 32'd5, 32'd0, "remu0");
    do_op(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
    do_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, "removf");

    // Backpressure
    @(negedge i_clk);
    i_valid = 1'b1; i_op = 4'd0; i_a = 32'd40; i_b = 32'd2; i_ready = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("bp/valid", o_valid, 1);
    held = o_res;
    chk("bp/res", held, 32'd42);
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1; i_op = 4'd1; i_a = 32'd9; i_b = 32'd1;
      @(negedge i_clk);
      chk("bp/hold", o_res, 32'd42);
      chk("bp/ready", o_ready, 0);
      chk("bp/validhold", o_valid, 1);
    end
    i_valid = 1'b0; i_ready = 1'b1;
    @(negedge i_clk);
    chk("bp/release_valid", o_valid, 0);
    chk("bp/release_ready", o_ready, 1);
    chk("bp/release_busy", o_busy, 0);

    // Reset mid-divide
    i_valid = 1'b1; i_op = 4'd13; i_a = 32'd1000; i_b = 32'd7;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    chk("mid/busy", o_busy, 1);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("mid/busy_rst", o_busy, 0);
    chk("mid/valid_rst", o_valid, 0);
    chk("mid/res_rst", o_res, 0);
    chk("mid/ready_rst", o_ready, 0);
    i_rst_n = 1'b1;
    do_op(4'd0, 32'd2, 32'd3, "postrst_add");

    // Randomized ops
    for (int n = 0; n < 60; n++) begin
      rop = 4'($urandom_range(0, 15));
      ea  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       eb = 32'd0;
        1:       eb = 32'hFFFF_FFFF;
        2:       eb = 32'($urandom_range(1, 20));
        default: eb = $urandom;
      endcase
      do_op(rop, ea, eb, $sformatf("rnd%0d_op%0d", n, rop));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
